// File: rtl/food_target_gen.sv
`default_nettype none
// ============================================================================
// Module   : food_target_gen
// Purpose  : Food position generator for the snake game. Relocates the food
//            to a pseudo-random in-field cell on every eat edge, counts eats
//            and requests WIN at WIN_SCORE. Optional FOOD_TIMEOUT_EN macro
//            adds an idle relocation timer (TIMEOUT_CYCLES).
// Revision : 1.0 - initial release
// ============================================================================
module food_target_gen #(
    parameter int          MAX_X          = 159,
    parameter int          MAX_Y          = 119,
    parameter int          WIN_SCORE      = 10,
    parameter int          START_X        = 40,
    parameter int          START_Y        = 30,
    parameter logic [7:0]  LFSR_H_SEED    = 8'hA5,
    parameter logic [6:0]  LFSR_V_SEED    = 7'h2B,
    parameter logic [24:0] TIMEOUT_CYCLES = 25'd30000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] MASTER_STATE,
    input  logic       TARGET_REACHED,
    output logic [7:0] FOOD_TARGET_H,
    output logic [6:0] FOOD_TARGET_V,
    output logic [3:0] SCORE,
    output logic       NEW_TARGET,
    output logic       WIN_REQ
);

    localparam logic [7:0] C_MAX_X     = 8'(MAX_X);
    localparam logic [7:0] C_SPAN_X    = 8'(MAX_X + 1);
    localparam logic [6:0] C_MAX_Y     = 7'(MAX_Y);
    localparam logic [6:0] C_SPAN_Y    = 7'(MAX_Y + 1);
    localparam logic [7:0] C_START_X   = 8'(START_X);
    localparam logic [6:0] C_START_Y   = 7'(START_Y);
    localparam logic [3:0] C_WIN_SCORE = 4'(WIN_SCORE);
    localparam logic [1:0] C_MS_IDLE   = 2'b00;
    localparam logic [1:0] C_MS_PLAY   = 2'b01;

    typedef enum logic [1:0] {
        ST_ARMED = 2'd0,
        ST_PICK  = 2'd1,
        ST_WON   = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 25'd2) begin : g_timeout_range_check
        $error("food_target_gen: TIMEOUT_CYCLES must be at least 2");
    end

    state_t      r_state;
    logic [7:0]  r_lfsr_h;
    logic [6:0]  r_lfsr_v;
    logic        r_treq_d;
    logic [7:0]  r_target_h;
    logic [6:0]  r_target_v;
    logic [3:0]  r_score;
    logic        r_new_target;
    logic        r_win_req;

    logic [7:0]  w_cx;
    logic [6:0]  w_cy;
    logic        w_eat;
    logic        w_same;
    logic        w_timeout;
    logic        w_reloc;
    logic [3:0]  w_score_inc;

    // Free-running maximal-length LFSRs; never stalled, never zero.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_lfsr_h <= LFSR_H_SEED;
            r_lfsr_v <= LFSR_V_SEED;
        end else begin
            r_lfsr_h <= {r_lfsr_h[6:0], r_lfsr_h[7] ^ r_lfsr_h[5] ^ r_lfsr_h[4] ^ r_lfsr_h[3]};
            r_lfsr_v <= {r_lfsr_v[5:0], r_lfsr_v[6] ^ r_lfsr_v[5]};
        end
    end

    // A single conditional subtract folds any LFSR value into the field.
    assign w_cx        = (r_lfsr_h > C_MAX_X) ? (r_lfsr_h - C_SPAN_X) : r_lfsr_h;
    assign w_cy        = (r_lfsr_v > C_MAX_Y) ? (r_lfsr_v - C_SPAN_Y) : r_lfsr_v;
    assign w_same      = (w_cx == r_target_h) && (w_cy == r_target_v);
    assign w_eat       = TARGET_REACHED & ~r_treq_d & (MASTER_STATE == C_MS_PLAY);
    assign w_score_inc = r_score + 4'd1;

`ifdef FOOD_TIMEOUT_EN
    logic [24:0] r_to_cnt;
    logic        r_reloc;

    assign w_timeout = (r_state == ST_ARMED) && (MASTER_STATE == C_MS_PLAY)
                       && (r_to_cnt == TIMEOUT_CYCLES - 25'd1);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_to_cnt <= '0;
        end else if ((MASTER_STATE != C_MS_PLAY) || (r_state != ST_ARMED) || w_eat || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 25'd1;
        end
    end

    // Remembers whether the pending PICK came from the timer (an eat wins ties).
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_reloc <= 1'b0;
        end else if ((r_state == ST_ARMED) && (MASTER_STATE == C_MS_PLAY) && (w_eat || w_timeout)) begin
            r_reloc <= ~w_eat;
        end
    end

    assign w_reloc = r_reloc;
`else
    assign w_timeout = 1'b0;
    assign w_reloc   = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= ST_ARMED;
            r_treq_d     <= 1'b0;
            r_target_h   <= C_START_X;
            r_target_v   <= C_START_Y;
            r_score      <= 4'd0;
            r_new_target <= 1'b0;
            r_win_req    <= 1'b0;
        end else begin
            r_treq_d     <= TARGET_REACHED;
            r_new_target <= 1'b0;
            if (MASTER_STATE == C_MS_IDLE) begin
                r_state    <= ST_ARMED;
                r_target_h <= C_START_X;
                r_target_v <= C_START_Y;
                r_score    <= 4'd0;
                r_win_req  <= 1'b0;
            end else if (MASTER_STATE == C_MS_PLAY) begin
                case (r_state)
                    ST_ARMED: begin
                        if (w_eat || w_timeout) begin
                            r_state <= ST_PICK;
                        end
                    end
                    ST_PICK: begin
                        // An equal candidate is retried; the LFSRs move on next cycle.
                        if (!w_same) begin
                            r_target_h   <= w_cx;
                            r_target_v   <= w_cy;
                            r_new_target <= 1'b1;
                            if (w_reloc) begin
                                r_state <= ST_ARMED;
                            end else begin
                                r_score <= w_score_inc;
                                if (w_score_inc == C_WIN_SCORE) begin
                                    r_state   <= ST_WON;
                                    r_win_req <= 1'b1;
                                end else begin
                                    r_state <= ST_ARMED;
                                end
                            end
                        end
                    end
                    ST_WON: begin
                        r_win_req <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_ARMED;
                    end
                endcase
            end
        end
    end

    assign FOOD_TARGET_H = r_target_h;
    assign FOOD_TARGET_V = r_target_v;
    assign SCORE         = r_score;
    assign NEW_TARGET    = r_new_target;
    assign WIN_REQ       = r_win_req;

endmodule
`default_nettype wire
